// File: rtl/ram_access_arbiter.sv
// Round-robin arbiter between the fetch (I) and load/store (D) ports that owns the
// MFA/MFC handshake of the 256x32 RAM, including opcode/alignment checks and an MFC watchdog.
module ram_access_arbiter #(
    parameter int         TIMEOUT  = 16,
    parameter logic [5:0] FETCH_OP = 6'h08
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [7:0]  i_addr,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    output logic        i_err,
    input  logic        d_req,
    input  logic [5:0]  d_op,
    input  logic [7:0]  d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        mem_MFA,
    output logic [5:0]  mem_opcode,
    output logic [7:0]  mem_addr,
    output logic [31:0] mem_data_in,
    input  logic        mem_MFC,
    input  logic [31:0] mem_data_out,
    output logic        busy,
    output logic        fault
);
    typedef enum logic [2:0] {IDLE, CHECK, SETUP, ACCESS, RELEASE, ERR} state_t;

    localparam int              CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state;
    logic              mfc_meta, mfc_s;
    logic              sel_d, last_d, grant_d;
    logic [5:0]        lat_op;
    logic [7:0]        lat_addr;
    logic [31:0]       lat_wdata;
    logic [CNT_W-1:0]  wd_cnt;
    logic              fin, fin_err;
    logic [31:0]       fin_data;

    function automatic logic op_legal(input logic [5:0] op);
        case (op)
            6'h01, 6'h09, 6'h02, 6'h0a, 6'h08, 6'h05, 6'h06, 6'h04: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic op_is_load(input logic [5:0] op);
        case (op)
            6'h01, 6'h09, 6'h02, 6'h0a, 6'h08: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic misaligned(input logic [5:0] op, input logic [7:0] addr);
        case (op)
            6'h02, 6'h0a, 6'h06: return addr[0];
            6'h08, 6'h04:        return addr[1:0] != 2'b00;
            default:             return 1'b0;
        endcase
    endfunction

    // D wins a tie unless it was the last port served; last_d resets low so D goes first.
    assign grant_d = d_req && (!i_req || !last_d);
    assign busy    = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mfc_meta <= 1'b0;
            mfc_s    <= 1'b0;
        end else begin
            mfc_meta <= mem_MFC;
            mfc_s    <= mfc_meta;
        end
    end

    // Request fields are datapath only; they are always rewritten before CHECK reads them.
    always_ff @(posedge clk) begin
        if (state == IDLE && (i_req || d_req)) begin
            lat_op    <= grant_d ? d_op    : FETCH_OP;
            lat_addr  <= grant_d ? d_addr  : i_addr;
            lat_wdata <= grant_d ? d_wdata : 32'h0;
        end
    end

    // Completion decode: a CHECK rejection or an ACCESS exit produces the next cycle's ack.
    always_comb begin
        fin      = 1'b0;
        fin_err  = 1'b0;
        fin_data = 32'h0;
        case (state)
            CHECK: begin
                if (!op_legal(lat_op) || misaligned(lat_op, lat_addr)) begin
                    fin     = 1'b1;
                    fin_err = 1'b1;
                end
            end
            ACCESS: begin
                if (mfc_s) begin
                    fin      = 1'b1;
                    fin_data = op_is_load(lat_op) ? mem_data_out : 32'h0;
                end else if (wd_cnt == WD_LAST) begin
                    fin     = 1'b1;
                    fin_err = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            sel_d       <= 1'b0;
            last_d      <= 1'b0;
            wd_cnt      <= '0;
            mem_MFA     <= 1'b0;
            mem_opcode  <= 6'h0;
            mem_addr    <= 8'h0;
            mem_data_in <= 32'h0;
            i_ack       <= 1'b0;
            i_err       <= 1'b0;
            i_rdata     <= 32'h0;
            d_ack       <= 1'b0;
            d_err       <= 1'b0;
            d_rdata     <= 32'h0;
            fault       <= 1'b0;
        end else begin
            i_ack <= fin && !sel_d;
            d_ack <= fin && sel_d;
            if (fin) begin
                if (sel_d) begin
                    d_err   <= fin_err;
                    d_rdata <= fin_data;
                end else begin
                    i_err   <= fin_err;
                    i_rdata <= fin_data;
                end
            end

            case (state)
                IDLE: begin
                    if (i_req || d_req) begin
                        sel_d  <= grant_d;
                        last_d <= grant_d;
                        state  <= CHECK;
                    end
                end
                CHECK: begin
                    if (fin) begin
                        state <= ERR;
                    end else begin
                        mem_opcode  <= lat_op;
                        mem_addr    <= lat_addr;
                        mem_data_in <= lat_wdata;
                        state       <= SETUP;
                    end
                end
                SETUP: begin
                    mem_MFA <= 1'b1;
                    wd_cnt  <= '0;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (fin) begin
                        mem_MFA <= 1'b0;
                        wd_cnt  <= '0;
                        state   <= RELEASE;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    // A RAM that never drops MFC is unrecoverable without reset.
                    if (!mfc_s) begin
                        state <= IDLE;
                    end else if (wd_cnt == WD_LAST) begin
                        fault <= 1'b1;
                        state <= IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
